pixel_writer: RTL and testbench

PIXEL_WRITER -- requirements
Module: pixel_writer

---
 rtl/pixel_writer.sv | 208 ++++++++++++++++++++
 tb/tb_pixel_writer.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/pixel_writer.sv
// -----------------------------------------------------------------------------
// pixel_writer
//   Accepts pixels as (x, y, color), drops off-screen ones (counting them), and
//   turns on-screen ones into framebuffer writes at y*H_RES+x, one per cycle, in
//   acceptance order. A clear request drains pixels already in flight, then
//   sweeps the whole framebuffer with a fill color before accepting more.
//
//   Pipeline: accept -> address stage -> FIFO -> write register, so a pixel
//   accepted at edge k appears on fb_we_out after edge k+2.
//
// Ports
//   clk_in          system clock, rising edge
//   rst_n_in        asynchronous active-low reset
//   pix_valid_in    pixel presented           pix_ready_out  pixel can be taken
//   x_in, y_in      signed pixel coordinates  color_in       pixel color
//   clear_in        one-cycle fill request    clear_color_in fill color
//   busy_out        drain or clear in progress
//   fb_we_out       framebuffer write strobe, with fb_addr_out / fb_data_out
//   clip_count_out  saturating count of discarded off-screen pixels
// -----------------------------------------------------------------------------
module pixel_writer #(
   parameter int H_RES      = 320,
   parameter int V_RES      = 180,
   parameter int ADDR_W     = 16,
   parameter int FIFO_DEPTH = 4
) (
   input  logic                clk_in,
   input  logic                rst_n_in,
   input  logic                pix_valid_in,
   output logic                pix_ready_out,
   input  logic signed [31:0]  x_in,
   input  logic signed [31:0]  y_in,
   input  logic [3:0]          color_in,
   input  logic                clear_in,
   input  logic [3:0]          clear_color_in,
   output logic                busy_out,
   output logic                fb_we_out,
   output logic [ADDR_W-1:0]   fb_addr_out,
   output logic [3:0]          fb_data_out,
   output logic [15:0]         clip_count_out
);

   localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int CNT_W = PTR_W + 1;

   localparam logic signed [31:0] H_RES_S   = 32'(H_RES);
   localparam logic signed [31:0] V_RES_S   = 32'(V_RES);
   localparam logic [ADDR_W-1:0]  LAST_ADDR = ADDR_W'(H_RES * V_RES - 1);
   localparam logic [PTR_W-1:0]   PTR_LAST  = PTR_W'(FIFO_DEPTH - 1);
   localparam logic [CNT_W-1:0]   CNT_FULL  = CNT_W'(FIFO_DEPTH);

   typedef enum logic [1:0] {
      S_RUN,
      S_DRAIN,
      S_CLEAR
   } state_t;

   typedef struct packed {
      logic [ADDR_W-1:0] addr;
      logic [3:0]        color;
   } entry_t;

   state_t            state_q,       state_d;
   logic [3:0]        clear_color_q, clear_color_d;
   logic [ADDR_W-1:0] sweep_q,       sweep_d;
   logic [15:0]       clip_q,        clip_d;
   logic              stage_valid_q, stage_valid_d;
   entry_t            stage_q,       stage_d;
   logic [PTR_W-1:0]  wr_ptr_q,      wr_ptr_d;
   logic [PTR_W-1:0]  rd_ptr_q,      rd_ptr_d;
   logic [CNT_W-1:0]  count_q,       count_d;
   logic              fb_we_q,       fb_we_d;
   logic [ADDR_W-1:0] fb_addr_q,     fb_addr_d;
   logic [3:0]        fb_data_q,     fb_data_d;

   entry_t            mem_q [FIFO_DEPTH];

   logic              accept;
   logic              on_screen;
   logic              push;
   logic              pop;
   logic [ADDR_W-1:0] lin_addr;
   entry_t            head;

   assign pix_ready_out  = (state_q == S_RUN) && (count_q != CNT_FULL);
   assign busy_out       = (state_q != S_RUN);
   assign fb_we_out      = fb_we_q;
   assign fb_addr_out    = fb_addr_q;
   assign fb_data_out    = fb_data_q;
   assign clip_count_out = clip_q;

   always_comb begin
      // NOTE: every signal written here gets a default first, so no path can
      // leave one unassigned and infer a latch.
      state_d       = state_q;
      clear_color_d = clear_color_q;
      sweep_d       = sweep_q;
      clip_d        = clip_q;
      stage_valid_d = 1'b0;
      stage_d       = stage_q;
      wr_ptr_d      = wr_ptr_q;
      rd_ptr_d      = rd_ptr_q;
      fb_we_d       = 1'b0;
      fb_addr_d     = fb_addr_q;
      fb_data_d     = fb_data_q;

      accept    = pix_valid_in && pix_ready_out;
      on_screen = (x_in >= 32'sd0) && (x_in < H_RES_S) &&
                  (y_in >= 32'sd0) && (y_in < V_RES_S);
      lin_addr  = ADDR_W'(y_in * H_RES_S + x_in);
      head      = mem_q[rd_ptr_q];

      // Address stage: on-screen pixels move on next cycle, off-screen ones are
      // only counted.
      if (accept) begin
         stage_d       = '{addr: lin_addr, color: color_in};
         stage_valid_d = on_screen;
         if (!on_screen && (clip_q != 16'hFFFF)) begin
            clip_d = clip_q + 16'd1;
         end
      end

      // The FIFO drains every cycle it holds data, so with one push per cycle
      // at most its occupancy never actually grows past one entry.
      push = stage_valid_q;
      pop  = (count_q != '0) && (state_q != S_CLEAR);

      if (push) begin
         wr_ptr_d = (wr_ptr_q == PTR_LAST) ? '0 : wr_ptr_q + PTR_W'(1);
      end
      if (pop) begin
         rd_ptr_d  = (rd_ptr_q == PTR_LAST) ? '0 : rd_ptr_q + PTR_W'(1);
         fb_we_d   = 1'b1;
         fb_addr_d = head.addr;
         fb_data_d = head.color;
      end
      count_d = count_q + CNT_W'(push) - CNT_W'(pop);

      unique case (state_q)
         S_RUN: begin
            if (clear_in) begin
               clear_color_d = clear_color_in;
               state_d       = S_DRAIN;
            end
         end
         S_DRAIN: begin
            // Wait for both the FIFO and the address stage to be empty, so the
            // sweep never overtakes a pixel accepted before the clear.
            if ((count_q == '0) && !stage_valid_q) begin
               sweep_d = '0;
               state_d = S_CLEAR;
            end
         end
         S_CLEAR: begin
            fb_we_d   = 1'b1;
            fb_addr_d = sweep_q;
            fb_data_d = clear_color_q;
            if (sweep_q == LAST_ADDR) begin
               state_d = S_RUN;
            end else begin
               sweep_d = sweep_q + ADDR_W'(1);
            end
         end
         default: state_d = S_RUN;
      endcase
   end

   // NOTE: state registers use non-blocking assignments so every flop samples
   // the pre-edge values regardless of statement order.
   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         state_q       <= S_RUN;
         clear_color_q <= '0;
         sweep_q       <= '0;
         clip_q        <= '0;
         stage_valid_q <= 1'b0;
         stage_q       <= '0;
         wr_ptr_q      <= '0;
         rd_ptr_q      <= '0;
         count_q       <= '0;
         fb_we_q       <= 1'b0;
         fb_addr_q     <= '0;
         fb_data_q     <= '0;
      end else begin
         state_q       <= state_d;
         clear_color_q <= clear_color_d;
         sweep_q       <= sweep_d;
         clip_q        <= clip_d;
         stage_valid_q <= stage_valid_d;
         stage_q       <= stage_d;
         wr_ptr_q      <= wr_ptr_d;
         rd_ptr_q      <= rd_ptr_d;
         count_q       <= count_d;
         fb_we_q       <= fb_we_d;
         fb_addr_q     <= fb_addr_d;
         fb_data_q     <= fb_data_d;
      end
   end

   // NOTE: the FIFO storage has no reset; resetting the pointers and count
   // already marks every entry invalid, and stale contents are never read.
   always_ff @(posedge clk_in) begin
      if (push) begin
         mem_q[wr_ptr_q] <= stage_q;
      end
   end

endmodule

// File: tb/tb_pixel_writer.sv
module tb_pixel_writer;

   localparam int H     = 320;
   localparam int V     = 180;
   localparam int AW    = 16;
   localparam int TOTAL = H * V;

   logic               clk_in = 1'b0;
   logic               rst_n_in;
   logic               pix_valid_in;
   logic               pix_ready_out;
   logic signed [31:0] x_in;
   logic signed [31:0] y_in;
   logic [3:0]         color_in;
   logic               clear_in;
   logic [3:0]         clear_color_in;
   logic               busy_out;
   logic               fb_we_out;
   logic [AW-1:0]      fb_addr_out;
   logic [3:0]         fb_data_out;
   logic [15:0]        clip_count_out;

   always #5 clk_in = ~clk_in;

   pixel_writer #(
      .H_RES(H), .V_RES(V), .ADDR_W(AW), .FIFO_DEPTH(4)
   ) dut (
      .clk_in         (clk_in),
      .rst_n_in       (rst_n_in),
      .pix_valid_in   (pix_valid_in),
      .pix_ready_out  (pix_ready_out),
      .x_in           (x_in),
      .y_in           (y_in),
      .color_in       (color_in),
      .clear_in       (clear_in),
      .clear_color_in (clear_color_in),
      .busy_out       (busy_out),
      .fb_we_out      (fb_we_out),
      .fb_addr_out    (fb_addr_out),
      .fb_data_out    (fb_data_out),
      .clip_count_out (clip_count_out)
   );

   typedef struct {
      int addr;
      int data;
      bit last;
   } wr_t;

   int  errors = 0;
   int  checks = 0;

   // Behavioural model: the ordered list of writes the framebuffer must see.
   wr_t exp_q[$];
   wr_t e;
   bit  m_busy = 1'b0;
   int  m_clip = 0;

   int  cyc = 0;
   int  n_writes = 0;
   int  last_wr_cyc = -1;
   int  last_wr_addr = -1;
   int  last_wr_data = -1;
   int  wr_cyc_q[$];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Model update on each rising edge, from the inputs the DUT also sees.
   initial forever begin
      @(posedge clk_in);
      cyc++;
      if (rst_n_in === 1'b1) begin
         if (!m_busy && pix_valid_in) begin
            if (x_in < 0 || x_in >= H || y_in < 0 || y_in >= V) begin
               if (m_clip < 65535) m_clip++;
            end else begin
               exp_q.push_back('{addr: y_in * H + x_in, data: int'(color_in), last: 1'b0});
            end
         end
         if (!m_busy && clear_in) begin
            m_busy = 1'b1;
            for (int a = 0; a < TOTAL; a++)
               exp_q.push_back('{addr: a, data: int'(clear_color_in), last: (a == TOTAL - 1)});
         end
      end
   end

   // Reset aborts everything in flight.
   initial forever begin
      @(negedge rst_n_in);
      exp_q.delete();
      m_busy = 1'b0;
      m_clip = 0;
   end

   // Compare process: outputs checked on every falling edge out of reset.
   initial forever begin
      @(negedge clk_in);
      if (rst_n_in === 1'b1) begin
         if (fb_we_out) begin
            n_writes++;
            last_wr_cyc  = cyc;
            last_wr_addr = int'(fb_addr_out);
            last_wr_data = int'(fb_data_out);
            wr_cyc_q.push_back(cyc);
            if (exp_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_write: got addr %0d data %0d, required no write", fb_addr_out, fb_data_out);
            end else begin
               e = exp_q.pop_front();
               check("wr_addr", fb_addr_out, e.addr);
               check("wr_data", fb_data_out, e.data);
               if (e.last) m_busy = 1'b0;
            end
         end
         check("busy", busy_out, m_busy);
         check("ready", pix_ready_out, !m_busy);
         check("clip", clip_count_out, m_clip);
      end
   end

   task automatic send(input int x, input int y, input int c, input bit clr, input int cc,
                       output int k);
      pix_valid_in   = 1'b1;
      x_in           = x;
      y_in           = y;
      color_in       = 4'(c);
      clear_in       = clr;
      clear_color_in = 4'(cc);
      @(posedge clk_in);
      k = cyc;
      #1;
      pix_valid_in   = 1'b0;
      clear_in       = 1'b0;
      x_in           = -77;
      y_in           = 9999;
      color_in       = 4'hE;
   endtask

   task automatic pulse_clear(input int cc);
      clear_in       = 1'b1;
      clear_color_in = 4'(cc);
      @(posedge clk_in);
      #1;
      clear_in       = 1'b0;
      clear_color_in = 4'h9;
   endtask

   int k, k0, w0;
   bit found;

   initial begin
      rst_n_in       = 1'b0;
      pix_valid_in   = 1'b0;
      x_in           = 0;
      y_in           = 0;
      color_in       = 4'h0;
      clear_in       = 1'b0;
      clear_color_in = 4'h0;

      repeat (3) @(posedge clk_in);
      #1;
      check("rst_fb_we", fb_we_out, 0);
      check("rst_fb_addr", fb_addr_out, 0);
      check("rst_fb_data", fb_data_out, 0);
      check("rst_clip", clip_count_out, 0);
      check("rst_busy", busy_out, 0);
      @(negedge clk_in);
      rst_n_in = 1'b1;
      #1;
      check("ready_after_reset", pix_ready_out, 1);
      @(posedge clk_in);
      #1;

      // Single pixel: addr 2*320+5 = 645, two edges after acceptance.
      w0 = n_writes;
      send(5, 2, 4'hA, 1'b0, 0, k);
      repeat (4) @(negedge clk_in);
      check("single_count", n_writes - w0, 1);
      check("single_latency", last_wr_cyc, k + 2);
      check("single_addr", last_wr_addr, 645);
      check("single_data", last_wr_data, 10);

      // Eight back-to-back pixels -> eight consecutive write cycles.
      wr_cyc_q.delete();
      for (int i = 0; i < 8; i++) begin
         send(i * 7, i + 1, i, 1'b0, 0, k);
         if (i == 0) k0 = k;
      end
      repeat (4) @(negedge clk_in);
      check("burst_count", wr_cyc_q.size(), 8);
      for (int i = 0; i < 8 && i < wr_cyc_q.size(); i++)
         check("burst_cycle", wr_cyc_q[i], k0 + 2 + i);
      check("burst_last_addr", last_wr_addr, 2609);
      check("burst_last_data", last_wr_data, 7);

      // Clipping: three off-screen pixels, one on-screen at 3*320+3 = 963.
      w0 = n_writes;
      send(-1, 0, 1, 1'b0, 0, k);
      send(320, 0, 2, 1'b0, 0, k);
      send(0, 180, 3, 1'b0, 0, k);
      send(3, 3, 6, 1'b0, 0, k);
      repeat (4) @(negedge clk_in);
      check("clip_count", clip_count_out, 3);
      check("clip_writes", n_writes - w0, 1);
      check("clip_addr", last_wr_addr, 963);
      check("clip_data", last_wr_data, 6);

      // Clear with three pixels in flight; a second clear mid-sweep is ignored.
      w0 = n_writes;
      send(10, 10, 1, 1'b0, 0, k);
      send(11, 10, 2, 1'b0, 0, k);
      send(12, 10, 3, 1'b1, 0, k);
      repeat (50) @(negedge clk_in);
      check("clear_busy", busy_out, 1);
      check("clear_ready", pix_ready_out, 0);
      #1;
      pulse_clear(4'hF);
      for (int i = 0; i < 60000 && busy_out; i++) @(negedge clk_in);
      check("clear_done_in_time", busy_out, 0);
      @(negedge clk_in);
      check("clear_total_writes", n_writes - w0, 3 + 57600);
      check("clear_last_addr", last_wr_addr, 57599);
      check("clear_last_data", last_wr_data, 0);
      check("clear_queue_empty", exp_q.size(), 0);
      check("clear_back_to_run", pix_ready_out, 1);

      // Reset in the middle of a sweep, at address 1000.
      #1;
      pulse_clear(4'h5);
      found = 1'b0;
      for (int i = 0; i < 2000 && !found; i++) begin
         @(negedge clk_in);
         if (fb_we_out && fb_addr_out == 16'd1000) found = 1'b1;
      end
      check("reached_addr_1000", found, 1);
      #2;
      rst_n_in = 1'b0;
      #1;
      check("abort_we", fb_we_out, 0);
      check("abort_busy", busy_out, 0);
      check("abort_addr", fb_addr_out, 0);
      @(posedge clk_in);
      @(negedge clk_in);
      #1;
      rst_n_in = 1'b1;
      #1;
      check("abort_ready", pix_ready_out, 1);
      w0 = n_writes;
      repeat (10) @(negedge clk_in);
      check("abort_no_writes", n_writes - w0, 0);
      check("abort_queue_empty", exp_q.size(), 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
